// File: rtl/perf_counter_unit_if.sv
// Register-bus port of the performance counter unit: single-cycle strobe,
// registered read data returned with a one-cycle valid pulse.
interface perf_counter_unit_if;
    logic        sel_i;
    logic        we_i;
    logic [2:0]  addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        rvalid_o;

    modport slave (
        input  sel_i, we_i, addr_i, wdata_i,
        output rdata_o, rvalid_o
    );

    modport master (
        output sel_i, we_i, addr_i, wdata_i,
        input  rdata_o, rvalid_o
    );
endinterface

// File: rtl/perf_counter_unit.sv
// Pipeline performance counters (cycles, retired, stalls, flushes, mispredicts)
// with automatic freeze once the fetch stream shows a run of all-zero words.
module perf_counter_unit #(
    parameter int HALT_CYCLES = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 retire_i,
    input  logic                 stalld_i,
    input  logic                 flushd_i,
    input  logic                 mispredict_i,
    input  logic [31:0]          fetch_word_i,
    perf_counter_unit_if.slave   bus,
    output logic                 done_o
);
    localparam int HW = $clog2(HALT_CYCLES + 1);
    localparam logic [HW-1:0] HALT_MAX  = HW'(HALT_CYCLES);
    localparam logic [HW-1:0] HALT_LAST = HW'(HALT_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [63:0]   r_cycle;
    logic [63:0]   r_instret;
    logic [31:0]   r_stall;
    logic [31:0]   r_flush;
    logic [31:0]   r_mispred;
    logic [31:0]   r_cycle_snap;
    logic [31:0]   r_instret_snap;
    logic [HW-1:0] r_halt_cnt;
    logic [31:0]   r_rdata;
    logic          r_rvalid;
    logic [31:0]   w_rdata;

    logic w_run, w_done, w_rd, w_ctrl_wr, w_wen, w_wclr, w_clr, w_halt_hit;
    logic w_unused_wdata;

    assign w_run      = (r_state == S_RUN);
    assign w_done     = (r_state == S_DONE);
    assign w_rd       = bus.sel_i && !bus.we_i;
    assign w_ctrl_wr  = bus.sel_i && bus.we_i && (bus.addr_i == 3'd0);
    assign w_wen      = bus.wdata_i[0];
    assign w_wclr     = bus.wdata_i[1];
    assign w_clr      = w_ctrl_wr && w_wclr;
    assign w_unused_wdata = &{1'b0, bus.wdata_i[31:2]};
    // Counter saturates at the threshold so a stale count can still re-trigger.
    assign w_halt_hit = w_run && (fetch_word_i == 32'd0) && (r_halt_cnt >= HALT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_ctrl_wr && w_wen) w_state_nxt = S_RUN;
            S_RUN: begin
                if (w_ctrl_wr && !w_wen)      w_state_nxt = S_IDLE;
                else if (w_halt_hit && !w_clr) w_state_nxt = S_DONE;
            end
            S_DONE:  if (w_ctrl_wr && (w_wclr || !w_wen)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_rdata = 32'd0;
        case (bus.addr_i)
            3'd0: w_rdata = {29'd0, w_done, 1'b0, (w_run || w_done)};
            3'd1: w_rdata = r_cycle[31:0];
            3'd2: w_rdata = r_cycle_snap;
            3'd3: w_rdata = r_instret[31:0];
            3'd4: w_rdata = r_instret_snap;
            3'd5: w_rdata = r_stall;
            3'd6: w_rdata = r_flush;
            3'd7: w_rdata = r_mispred;
            default: w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_cycle        <= 64'd0;
            r_instret      <= 64'd0;
            r_stall        <= 32'd0;
            r_flush        <= 32'd0;
            r_mispred      <= 32'd0;
            r_cycle_snap   <= 32'd0;
            r_instret_snap <= 32'd0;
            r_halt_cnt     <= '0;
            r_rdata        <= 32'd0;
            r_rvalid       <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rvalid <= w_rd;
            if (w_rd) r_rdata <= w_rdata;
            if (w_rd && bus.addr_i == 3'd1) r_cycle_snap   <= r_cycle[63:32];
            if (w_rd && bus.addr_i == 3'd3) r_instret_snap <= r_instret[63:32];

            // Clear takes priority over any event seen in the same cycle.
            if (w_clr) begin
                r_cycle    <= 64'd0;
                r_instret  <= 64'd0;
                r_stall    <= 32'd0;
                r_flush    <= 32'd0;
                r_mispred  <= 32'd0;
                r_halt_cnt <= '0;
            end else if (w_run) begin
                r_cycle <= r_cycle + 64'd1;
                if (retire_i)                           r_instret <= r_instret + 64'd1;
                if (stalld_i     && r_stall   != '1)    r_stall   <= r_stall + 32'd1;
                if (flushd_i     && r_flush   != '1)    r_flush   <= r_flush + 32'd1;
                if (mispredict_i && r_mispred != '1)    r_mispred <= r_mispred + 32'd1;
                if (fetch_word_i != 32'd0)              r_halt_cnt <= '0;
                else if (r_halt_cnt < HALT_MAX)         r_halt_cnt <= r_halt_cnt + 1'b1;
            end
        end
    end

    assign bus.rdata_o  = r_rdata;
    assign bus.rvalid_o = r_rvalid;
    assign done_o       = w_done;
endmodule

// File: tb/tb_perf_counter_unit.sv
// Directed bench for perf_counter_unit: hand-computed expectations per scenario.
module tb_perf_counter_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        retire_i, stalld_i, flushd_i, mispredict_i;
    logic [31:0] fetch_word_i;
    logic        done_o;
    logic [31:0] rd;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    perf_counter_unit_if bus();

    perf_counter_unit #(.HALT_CYCLES(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .retire_i     (retire_i),
        .stalld_i     (stalld_i),
        .flushd_i     (flushd_i),
        .mispredict_i (mispredict_i),
        .fetch_word_i (fetch_word_i),
        .bus          (bus),
        .done_o       (done_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        bus.sel_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = a; bus.wdata_i = d;
        @(negedge clk);
        bus.sel_i = 1'b0; bus.we_i = 1'b0;
        chk("wr_no_rvalid", bus.rvalid_o, 1'b0);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        bus.sel_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = a;
        @(negedge clk);
        bus.sel_i = 1'b0;
        chk({tag, "_rvalid"}, bus.rvalid_o, 1'b1);
        chk(tag, bus.rdata_o, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; retire_i = 0; stalld_i = 0; flushd_i = 0; mispredict_i = 0;
        fetch_word_i = 32'h13;
        bus.sel_i = 0; bus.we_i = 0; bus.addr_i = 0; bus.wdata_i = 0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        chk("rst_done", done_o, 1'b0);
        chk("rst_rvalid", bus.rvalid_o, 1'b0);
        chk("rst_rdata", bus.rdata_o, 32'd0);
        rd_chk("rst_ctrl", 3'd0, 32'd0);
        rd_chk("rst_cyclo", 3'd1, 32'd0);

        // 10 RUN cycles, retire in 7; EN=0 issued in the 10th so it still counts
        bus_wr(3'd0, 32'd1);
        for (int i = 0; i < 10; i++) begin
            retire_i = (i < 7);
            if (i == 9) begin
                bus.sel_i = 1; bus.we_i = 1; bus.addr_i = 3'd0; bus.wdata_i = 32'd0;
            end
            @(negedge clk);
        end
        bus.sel_i = 0; bus.we_i = 0; retire_i = 0;
        rd_chk("run_cyclo", 3'd1, 32'd10);
        rd_chk("run_instlo", 3'd3, 32'd7);
        rd_chk("run_stall", 3'd5, 32'd0);
        rd_chk("run_ctrl", 3'd0, 32'd0);
        rd_chk("run_cychi", 3'd2, 32'd0);

        // halt: 4 zeros, one nonzero, 5 zeros -> DONE only after 5th zero
        bus_wr(3'd0, 32'd3);
        for (int i = 0; i < 10; i++) begin
            fetch_word_i = (i == 4) ? 32'h13 : 32'd0;
            @(negedge clk);
            chk("halt_done", done_o, (i == 9));
        end
        fetch_word_i = 32'h13;
        retire_i = 1;
        repeat (3) @(negedge clk);
        retire_i = 0;
        chk("halt_hold", done_o, 1'b1);
        rd_chk("halt_cyclo", 3'd1, 32'd10);
        rd_chk("halt_inst", 3'd3, 32'd0);
        rd_chk("halt_ctrl", 3'd0, 32'd5);
        bus_wr(3'd0, 32'd2);
        chk("clr_done", done_o, 1'b0);
        rd_chk("clr_cyclo", 3'd1, 32'd0);

        // CLR coincident with retire/flush events
        bus_wr(3'd0, 32'd1);
        retire_i = 1; flushd_i = 1;
        repeat (3) @(negedge clk);
        retire_i = 0; flushd_i = 0;
        rd_chk("pre_inst", 3'd3, 32'd3);
        rd_chk("pre_flush", 3'd6, 32'd3);
        retire_i = 1; flushd_i = 1;
        bus.sel_i = 1; bus.we_i = 1; bus.addr_i = 3'd0; bus.wdata_i = 32'd3;
        @(negedge clk);
        bus.sel_i = 0; bus.we_i = 0; retire_i = 0; flushd_i = 0;
        rd_chk("clrw_inst", 3'd3, 32'd0);
        rd_chk("clrw_flush", 3'd6, 32'd0);
        rd_chk("clrw_ctrl", 3'd0, 32'd1);
        rd_chk("clrw_insthi", 3'd4, 32'd0);
        bus_wr(3'd0, 32'd0);

        // 64-bit carry and HI snapshot semantics
        force dut.r_cycle = 64'h0000_0000_FFFF_FFFF;
        #1 release dut.r_cycle;
        bus_wr(3'd0, 32'd1);
        bus_wr(3'd0, 32'd0);
        rd_chk("wrap_lo", 3'd1, 32'd0);
        rd_chk("wrap_hi", 3'd2, 32'd1);
        force dut.r_cycle = 64'h0000_0007_0000_0003;
        #1 release dut.r_cycle;
        rd_chk("snap_hi_old", 3'd2, 32'd1);
        rd_chk("snap_lo", 3'd1, 32'd3);
        rd_chk("snap_hi_new", 3'd2, 32'd7);

        // STALL saturation, MISPRED count, writes to counter addresses ignored
        force dut.r_stall = 32'hFFFF_FFFD;
        #1 release dut.r_stall;
        bus_wr(3'd0, 32'd1);
        for (int i = 0; i < 5; i++) begin
            stalld_i = 1; mispredict_i = (i < 2);
            if (i == 4) begin
                bus.sel_i = 1; bus.we_i = 1; bus.addr_i = 3'd0; bus.wdata_i = 32'd0;
            end
            @(negedge clk);
        end
        bus.sel_i = 0; bus.we_i = 0; stalld_i = 0; mispredict_i = 0;
        rd_chk("sat_stall", 3'd5, 32'hFFFF_FFFF);
        rd_chk("mispred", 3'd7, 32'd2);
        bus_wr(3'd5, 32'd0);
        rd_chk("ro_stall", 3'd5, 32'hFFFF_FFFF);
        bus_wr(3'd1, 32'd0);
        rd_chk("ro_cyclo", 3'd1, 32'd8);
        rd_chk("ro_cychi", 3'd2, 32'd7);

        // reset while in DONE with a read in flight
        bus_wr(3'd0, 32'd1);
        fetch_word_i = 32'd0;
        repeat (5) @(negedge clk);
        chk("pre_rst_done", done_o, 1'b1);
        reset = 1'b0;
        bus.sel_i = 1; bus.we_i = 0; bus.addr_i = 3'd1;
        @(negedge clk);
        reset = 1'b1; bus.sel_i = 0; fetch_word_i = 32'h13;
        chk("mid_rst_done", done_o, 1'b0);
        chk("mid_rst_rvalid", bus.rvalid_o, 1'b0);
        chk("mid_rst_rdata", bus.rdata_o, 32'd0);
        rd_chk("mid_rst_stall", 3'd5, 32'd0);
        rd_chk("mid_rst_cychi", 3'd2, 32'd0);
        rd_chk("mid_rst_cyclo", 3'd1, 32'd0);
        rd_chk("mid_rst_misp", 3'd7, 32'd0);
        rd_chk("mid_rst_ctrl", 3'd0, 32'd0);
        @(negedge clk);
        chk("rvalid_pulse", bus.rvalid_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/perf_counter_unit.md
PERF_COUNTER_UNIT -- requirements
Module: perf_counter_unit

Interface
REQ-001 SHALL have parameter HALT_CYCLES, default 5: consecutive all-zero fetch words that mark program end.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-004 SHALL have port retire_i  in  1  non-bubble instruction retired in WB this cycle.
REQ-005 SHALL have port stalld_i  in  1  hazard-unit decode stall.
REQ-006 SHALL have port flushd_i  in  1  hazard-unit decode flush.
REQ-007 SHALL have port mispredict_i  in  1  branch resolved in EX against BPU prediction.
REQ-008 SHALL have port fetch_word_i  in  32  instruction word leaving instruction ROM.
REQ-009 SHALL have port sel_i  in  1  bus access strobe, single cycle.
REQ-010 SHALL have port we_i  in  1  1 = write, 0 = read.
REQ-011 SHALL have port addr_i  in  3  word index into register map.
REQ-012 SHALL have port wdata_i  in  32  write data.
REQ-013 SHALL have port rdata_o  out  32  registered read data.
REQ-014 SHALL have port rvalid_o  out  1  rdata_o valid, one-cycle pulse.
REQ-015 SHALL have port done_o  out  1  program-end detected, counters frozen.

Function
REQ-016 SHALL use register map: 0 CTRL (bit0 EN rw, bit1 CLR w1 self-clearing, bit2 DONE ro); 1 CYCLE_LO; 2 CYCLE_HI; 3 INSTRET_LO; 4 INSTRET_HI; 5 STALL; 6 FLUSH; 7 MISPRED.
REQ-017 SHALL implement FSM IDLE/RUN/DONE: IDLE->RUN on CTRL write EN=1; RUN->IDLE on EN=0; RUN->DONE when halt detected; DONE->IDLE on CLR or EN=0 write.
REQ-018 SHALL, in RUN only, increment CYCLE by 1 every cycle and INSTRET on retire_i, STALL on stalld_i, FLUSH on flushd_i, MISPRED on mispredict_i; all counters hold in IDLE and DONE.
REQ-019 SHALL keep CYCLE and INSTRET 64-bit, wrapping modulo 2^64; STALL, FLUSH, MISPRED 32-bit, saturating at 0xFFFFFFFF.
REQ-020 SHALL count halt with an internal run counter: +1 each RUN cycle fetch_word_i==0, cleared on nonzero word; reaching HALT_CYCLES moves FSM to DONE next edge.
REQ-021 SHALL count events in the cycle the halt threshold is reached; no counter changes from the first DONE cycle on.
REQ-022 SHALL assert done_o and CTRL.DONE exactly while in DONE.
REQ-023 SHALL on CLR zero all counters and halt run counter next edge; CLR wins over a simultaneous event; EN in same write word is applied.
REQ-024 SHALL apply CTRL writes at the next edge; events in the write cycle are counted under the old state.
REQ-025 SHALL return read data one cycle after sel_i&&!we_i with rvalid_o high for exactly that cycle; writes produce no rvalid_o.
REQ-026 SHALL latch upper 32 bits of CYCLE (INSTRET) into a snapshot when CYCLE_LO (INSTRET_LO) is read; CYCLE_HI (INSTRET_HI) returns the snapshot, not the live value.
REQ-027 SHALL ignore writes to addresses 1-7; reads of CTRL return bit1 as 0 and bits 31:3 as 0.

Reset
REQ-028 SHALL, while reset==0 at a clock edge, clear all counters, snapshots, halt run counter; FSM=IDLE; rdata_o=0, rvalid_o=0, done_o=0.
REQ-029 SHALL let reset override any bus access or event in the same cycle, including mid-DONE and mid-read (rvalid_o suppressed).

Verification
REQ-030 SHALL pass: EN=1, 10 RUN cycles, retire_i high 7 of them -> CYCLE_LO=10, INSTRET_LO=7, STALL=0.
REQ-031 SHALL pass: RUN, fetch_word_i=0 for 4 cycles then nonzero then 5 zeros -> DONE only after 5th consecutive zero, done_o=1, CYCLE frozen thereafter.
REQ-032 SHALL pass: preload CYCLE=0x0000_0000_FFFF_FFFF, run 1 cycle -> CYCLE_HI=1, CYCLE_LO=0; read LO then run 2^32 cycles less than wrap -> HI returns snapshot value.
REQ-033 SHALL pass: STALL at 0xFFFFFFFF plus stalld_i high 3 cycles -> STALL stays 0xFFFFFFFF.
REQ-034 SHALL pass: CLR write same cycle as retire_i, flushd_i -> INSTRET=0, FLUSH=0 next cycle, CTRL reads CLR=0.
REQ-035 SHALL pass: reset asserted in DONE with read pending -> next cycle done_o=0, rvalid_o=0, all counters 0.
